// File: rtl/tremolo_pkg.sv
// Shared types and gain arithmetic for the tremolo block.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package tremolo_pkg;

  typedef enum logic {WAVE_TRI = 1'b0, WAVE_SQR = 1'b1} wave_e;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  // Gain for one LFO level: FULL minus the depth-scaled distance of L below MAX.
  // Computed at 32/64 bits so any LFO_W up to 31 fits; the caller truncates to LFO_W+1.
  function automatic logic [31:0] calc_gain(input logic [31:0] l,
                                            input logic [31:0] depth,
                                            input logic        bypass,
                                            input int unsigned lfo_w);
    logic [31:0] full;
    logic [31:0] max_v;
    logic [31:0] atten;
    logic [63:0] prod;
    full      = 32'd1 << lfo_w;
    max_v     = full - 32'd1;
    prod      = {32'd0, depth} * {32'd0, max_v - l};
    atten     = 32'(prod >> lfo_w);
    calc_gain = bypass ? full : (full - atten);
  endfunction

endpackage

// File: rtl/tremolo_lfo.sv
// LFO: prescaler plus triangle/square phase generator; L is combinational, lfo_out registered.
// Latency: lfo_out trails L by one CLK.
// Backpressure: none, free-running regardless of the sample stream.
module tremolo_lfo
  import tremolo_pkg::*;
#(
  parameter int LFO_W = 8,
  parameter int DIV_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             wave_sel,
  output logic [LFO_W-1:0] lvl,
  output logic [LFO_W-1:0] lfo_out
);

  localparam logic [LFO_W-1:0] MAX = '1;

  logic [DIV_W-1:0] cnt;
  logic [LFO_W-1:0] p;
  dir_e             dir;
  logic             step;

  // >= rather than == so a rate_div lowered below the running count still steps at once
  assign step = (cnt >= rate_div);

  assign lvl = (wave_e'(wave_sel) == WAVE_SQR) ? ((dir == DIR_UP) ? MAX : '0) : p;

  // Prescaler: restart on every LFO step
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       cnt <= '0;
    else if (step) cnt <= '0;
    else           cnt <= cnt + DIV_W'(1);
  end

  // Triangle phase: direction flips on arriving at an end, giving 2*MAX steps per period
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p   <= '0;
      dir <= DIR_UP;
    end else if (step) begin
      if (dir == DIR_UP) begin
        p <= p + LFO_W'(1);
        if (p == MAX - LFO_W'(1)) dir <= DIR_DOWN;
      end else begin
        p <= p - LFO_W'(1);
        if (p == LFO_W'(1)) dir <= DIR_UP;
      end
    end
  end

  // Registered copy of L for observation
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfo_out <= '0;
    else     lfo_out <= lvl;
  end

endmodule

// File: rtl/tremolo_mod.sv
// N-channel tremolo: each sample scaled by an LFO-derived gain (TREMOLO_AUTOPAN_EN: odd channels use inverted LFO).
// Latency: 2 CLK from accept to out_valid, one frame per CLK.
// Backpressure: in_ready = !out_valid || out_ready; a stall freezes both stages and out_data.
module tremolo_mod
  import tremolo_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int NCH      = 2,
  parameter int LFO_W    = 8,
  parameter int DIV_W    = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*SAMPLE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*SAMPLE_W-1:0] out_data,
  input  logic [DIV_W-1:0]        rate_div,
  input  logic [LFO_W-1:0]        depth,
  input  logic                    wave_sel,
  input  logic                    bypass,
  output logic [LFO_W-1:0]        lfo_out
);

  localparam int GW = LFO_W + 1;
  localparam int PW = SAMPLE_W + LFO_W + 2;

  logic [LFO_W-1:0]        lvl;
  logic [GW-1:0]           g_even;
  logic                    advance;
  logic                    s1_vld;
  logic [NCH*SAMPLE_W-1:0] s1_data;
  logic [GW-1:0]           s1_g_even;
  logic [NCH*SAMPLE_W-1:0] y_all;

  tremolo_lfo #(.LFO_W(LFO_W), .DIV_W(DIV_W)) u_lfo (
    .CLK      (CLK),
    .RST      (RST),
    .rate_div (rate_div),
    .wave_sel (wave_sel),
    .lvl      (lvl),
    .lfo_out  (lfo_out)
  );

  // Gain from the current (pre-step) L, so a capture coinciding with a step uses the old level
  assign g_even = GW'(calc_gain(32'(lvl), 32'(depth), bypass, LFO_W));

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: capture the frame together with the gain it will be scaled by
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_vld    <= 1'b0;
      s1_data   <= '0;
      s1_g_even <= '0;
    end else if (advance) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_data   <= in_data;
        s1_g_even <= g_even;
      end
    end
  end

`ifdef TREMOLO_AUTOPAN_EN
  localparam logic [LFO_W-1:0] MAX = '1;
  logic [GW-1:0] g_odd;
  logic [GW-1:0] s1_g_odd;

  assign g_odd = GW'(calc_gain(32'(MAX - lvl), 32'(depth), bypass, LFO_W));

  // S1 odd-channel gain, captured alongside the even one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      s1_g_odd <= '0;
    else if (advance && in_valid) s1_g_odd <= g_odd;
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [GW-1:0] g_c;
`ifdef TREMOLO_AUTOPAN_EN
    assign g_c = (c % 2 == 1) ? s1_g_odd : s1_g_even;
`else
    assign g_c = s1_g_even;
`endif
    // g <= FULL keeps the shifted product inside SAMPLE_W; g == FULL is bit-exact unity
    assign y_all[c*SAMPLE_W +: SAMPLE_W] =
      SAMPLE_W'((PW'($signed(s1_data[c*SAMPLE_W +: SAMPLE_W])) *
                 PW'($signed({1'b0, g_c}))) >>> LFO_W);
  end

  // S2: register the scaled frame; held while downstream stalls
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= s1_vld;
      if (s1_vld) out_data <= y_all;
    end
  end

endmodule

// File: tb/tb_tremolo_mod.sv
// Directed + randomized bench for tremolo_mod with a scoreboard built from the arithmetic rules.
// Latency: n/a.
// Backpressure: out_ready is randomized and held low for stall checks.
module tb_tremolo_mod;

  localparam int MAXV = 255;
  localparam int FULL = 256;
  localparam int PER  = 2 * MAXV;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] rate_div;
  logic [7:0]  depth;
  logic        wave_sel;
  logic        bypass;
  logic [7:0]  lfo_out;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  longint      m_cnt;
  int          m_n;
  int          m_lfo;
  int          m_tri;
  logic [31:0] sb[$];

  tremolo_mod #(.SAMPLE_W(16), .NCH(2), .LFO_W(8), .DIV_W(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rate_div(rate_div), .depth(depth), .wave_sel(wave_sel), .bypass(bypass), .lfo_out(lfo_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // triangle level after n steps from reset
  function automatic int tri_at(int n);
    int v;
    v = n % PER;
    return (v <= MAXV) ? v : PER - v;
  endfunction

  function automatic int lval(int n, bit sq);
    if (!sq) return tri_at(n);
    return ((n % PER) < MAXV) ? MAXV : 0;
  endfunction

  // floor(x * g / FULL) with g from the depth/level rule
  function automatic logic [15:0] exp_y(int x, int l, int dep, bit byp);
    int     g;
    longint p;
    longint q;
    g = byp ? FULL : FULL - (dep * (MAXV - l)) / FULL;
    p = longint'(x) * g;
    if (p >= 0) q = p / FULL;
    else        q = -((-p + FULL - 1) / FULL);
    return q[15:0];
  endfunction

  // Reference model: LFO step counting and frame scoreboard, evaluated on pre-edge values
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_cnt = 0;
      m_n   = 0;
      m_lfo = 0;
      m_tri = 0;
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        logic [31:0] e;
        for (int c = 0; c < 2; c++) begin
          int l;
          l = lval(m_n, wave_sel);
`ifdef TREMOLO_AUTOPAN_EN
          if (c == 1) l = MAXV - l;
`endif
          e[c*16 +: 16] = exp_y(int'($signed(in_data[c*16 +: 16])), l, int'(depth), bypass);
        end
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 64'(out_data), 64'hDEAD_0000_0000);
        else                chk("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
      m_lfo = lval(m_n, wave_sel);
      m_tri = tri_at(m_n);
      if (m_cnt >= longint'(rate_div)) begin
        m_cnt = 0;
        m_n++;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit rnd_ready);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge CLK);
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      w++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    @(negedge CLK);
  endtask

  task automatic drain();
    int w;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge CLK);
      w++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [31:0] fr;
    int          acc;
    RST = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    rate_div = 32'd0; depth = 8'd0; wave_sel = 1'b0; bypass = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_lfo_out",   64'(lfo_out),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    RST = 1'b0;

    // triangle at full rate, more than one period
    repeat (PER + 10) begin
      @(negedge CLK);
      chk("lfo_tri", 64'(lfo_out), 64'(m_lfo));
    end
    // square: check away from the triangle turning points
    wave_sel = 1'b1;
    repeat (PER + 10) begin
      @(negedge CLK);
      if (m_tri != 0 && m_tri != MAXV) chk("lfo_sqr", 64'(lfo_out), 64'(m_lfo));
    end
    // rate changes mid-count, including lowering below the running count
    wave_sel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (i % 17 == 0) rate_div = $urandom_range(0, 9);
      chk("lfo_rate", 64'(lfo_out), 64'(m_lfo));
    end

    // unity gain: depth 0, L frozen at 0
    rate_div = 32'hFFFF_FFFF;
    pulse_reset();
    send(32'hFFFB_4000, 1'b0);
    chk("lat_early", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("unity_valid", 64'(out_valid), 64'd1);
    chk("unity_data",  64'(out_data),  64'hFFFB_4000);
    drain();

    // maximum depth at L=0
    depth = 8'd255;
    send({16'd1000, 16'h8000}, 1'b0);
    send({16'd1000, 16'd1000}, 1'b0);
`ifdef TREMOLO_AUTOPAN_EN
    chk("maxdepth_a", 64'(out_data), 64'h03E8_FF00);
`else
    chk("maxdepth_a", 64'(out_data), 64'h0007_FF00);
`endif
    in_valid = 1'b0;
    @(negedge CLK);
`ifdef TREMOLO_AUTOPAN_EN
    chk("maxdepth_b", 64'(out_data), 64'h03E8_0007);
`else
    chk("maxdepth_b", 64'(out_data), 64'h0007_0007);
`endif
    drain();

    // randomized frames, controls and backpressure with a moving LFO
    for (int i = 0; i < 250; i++) begin
      if (i % 10 == 0) begin
        rate_div = $urandom_range(0, 3);
        depth    = 8'($urandom);
        bypass   = ($urandom_range(0, 7) == 0);
        wave_sel = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(negedge CLK);
      end
      send($urandom, 1'b1);
    end
    drain();

    // backpressure: out_ready low for 5 cycles with continuous input
    rate_div = 32'hFFFF_FFFF; depth = 8'd128; bypass = 1'b0; wave_sel = 1'b0;
    pulse_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fr        = 32'h1234_0100;
    in_data   = fr;
    acc       = 0;
    held      = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bit took;
      #1;
      took = in_ready;
      if (took) acc++;
      @(negedge CLK);
      if (took) begin
        fr      = fr + 32'h0011_0101;
        in_data = fr;
      end
      if (cyc == 2) held = out_data;
    end
    #1;
    chk("bp_accepts",   64'(acc),      64'd2);
    chk("bp_in_ready",  64'(in_ready), 64'd0);
    chk("bp_held_data", 64'(out_data), 64'(held));
    @(negedge CLK);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(fr, 1'b0);
      fr = fr + 32'h0011_0101;
    end
    drain();

    // asynchronous reset while stalled with the LFO running
    rate_div = 32'd0;
    out_ready = 1'b0;
    send(32'h0AAA_0555, 1'b0);
    send(32'h0BBB_0666, 1'b0);
    repeat (5) @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    chk("midrst_lfo_out",   64'(lfo_out),   64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
